// File: rtl/fazyrv_spm_addr_if.sv
// Request/data bundle of the chunked address scratchpad. The slave modport is
// the scratchpad itself, and the master modport is the core that drives it.
interface fazyrv_spm_addr_if #(
    parameter int BWIDTH = 8,
    parameter int WIDTH  = 32
);
    localparam int NCH = WIDTH / BWIDTH;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    logic              clr_i;
    logic              ld_i;
    logic [WIDTH-1:0]  par_i;
    logic              shft_i;
    logic              rot_i;
    logic              inc_i;
    logic [BWIDTH-1:0] ser_i;
    logic [BWIDTH-1:0] ser_o;
    logic [WIDTH-1:0]  par_o;
    logic [CW-1:0]     cnt_o;
    logic              done_o;
    logic              ovf_o;

    modport slave (
        input  clr_i, ld_i, par_i, shft_i, rot_i, inc_i, ser_i,
        output ser_o, par_o, cnt_o, done_o, ovf_o
    );

    modport master (
        output clr_i, ld_i, par_i, shft_i, rot_i, inc_i, ser_i,
        input  ser_o, par_o, cnt_o, done_o, ovf_o
    );
endinterface

// File: rtl/fazyrv_spm_addr.sv
// Address scratchpad that shifts the register by BWIDTH-bit chunks, LSB chunk first.
// It supports serial fill, rotate, and a serial constant increment (for example PC+4).
module fazyrv_spm_addr #(
    parameter int               BWIDTH  = 8,
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] INC_VAL = WIDTH'(4)
) (
    input  logic                      clk_i,
    input  logic                      rst_in,
    fazyrv_spm_addr_if.slave          bus
);
    localparam int NCH = WIDTH / BWIDTH;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int AW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0]  reg_q, reg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;

    logic              last_s;
    logic              cin_s;
    logic [AW-1:0]     base_s;
    logic [BWIDTH-1:0] inc_chunk_s;
    logic [BWIDTH:0]   sum_s;
    logic [BWIDTH-1:0] new_chunk_s;
    logic [WIDTH-1:0]  shifted_s;

    // Next-state logic: clear beats load, and load beats shift.
    always_comb begin
        reg_d       = reg_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        done_d      = 1'b0;
        ovf_d       = ovf_q;
        last_s      = (cnt_q == CW'(NCH - 1));
        cin_s       = (cnt_q == CW'(0)) ? 1'b0 : carry_q;
        base_s      = AW'(cnt_q) * AW'(BWIDTH);
        inc_chunk_s = INC_VAL[base_s +: BWIDTH];
        sum_s       = {1'b0, reg_q[BWIDTH-1:0]} + {1'b0, inc_chunk_s} + (BWIDTH+1)'(cin_s);
        new_chunk_s = bus.ser_i;
        shifted_s   = reg_q >> BWIDTH;

        if (bus.clr_i) begin
            reg_d   = '0;
            cnt_d   = '0;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
        end else if (bus.ld_i) begin
            reg_d   = bus.par_i;
            cnt_d   = '0;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
        end else if (bus.shft_i) begin
            // A new word drops the previous overflow unless this shift also ends the word.
            if ((cnt_q == CW'(0)) && !last_s) begin
                ovf_d = 1'b0;
            end else begin
                ovf_d = ovf_q;
            end

            if (!bus.rot_i) begin
                new_chunk_s = bus.ser_i;
                carry_d     = 1'b0;
            end else if (!bus.inc_i) begin
                new_chunk_s = reg_q[BWIDTH-1:0];
                carry_d     = 1'b0;
            end else begin
                new_chunk_s = sum_s[BWIDTH-1:0];
                if (last_s) begin
                    carry_d = 1'b0;
                    ovf_d   = sum_s[BWIDTH];
                end else begin
                    carry_d = sum_s[BWIDTH];
                end
            end

            reg_d  = shifted_s | (WIDTH'(new_chunk_s) << (WIDTH - BWIDTH));
            cnt_d  = last_s ? CW'(0) : cnt_q + CW'(1);
            done_d = last_s;
        end else begin
            reg_d = reg_q;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            reg_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            reg_q   <= reg_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.ser_o  = reg_q[BWIDTH-1:0];
    assign bus.par_o  = reg_q;
    assign bus.cnt_o  = cnt_q;
    assign bus.done_o = done_q;
    assign bus.ovf_o  = ovf_q;
endmodule

// File: tb/tb_fazyrv_spm_addr.sv
// Directed self-checking bench for fazyrv_spm_addr. It uses the default 8-bit build,
// plus 1-bit and 2-bit chunk builds that rerun the serial increment.
module tb_fazyrv_spm_addr;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    fazyrv_spm_addr_if #(.BWIDTH(8), .WIDTH(32)) b8 ();
    fazyrv_spm_addr_if #(.BWIDTH(1), .WIDTH(32)) b1 ();
    fazyrv_spm_addr_if #(.BWIDTH(2), .WIDTH(32)) b2 ();

    fazyrv_spm_addr #(.BWIDTH(8), .WIDTH(32), .INC_VAL(32'd4)) dut8 (.clk_i(clk), .rst_in(rst_n), .bus(b8));
    fazyrv_spm_addr #(.BWIDTH(1), .WIDTH(32), .INC_VAL(32'd4)) dut1 (.clk_i(clk), .rst_in(rst_n), .bus(b1));
    fazyrv_spm_addr #(.BWIDTH(2), .WIDTH(32), .INC_VAL(32'd4)) dut2 (.clk_i(clk), .rst_in(rst_n), .bus(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle8();
        b8.clr_i = 1'b0; b8.ld_i = 1'b0; b8.shft_i = 1'b0;
        b8.rot_i = 1'b0; b8.inc_i = 1'b0; b8.ser_i = 8'h00; b8.par_i = 32'h0;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst_n = 1'b0;
        b1.clr_i = 1'b0; b1.ld_i = 1'b0; b1.shft_i = 1'b0; b1.rot_i = 1'b0;
        b1.inc_i = 1'b0; b1.ser_i = 1'b0; b1.par_i = 32'h0;
        b2.clr_i = 1'b0; b2.ld_i = 1'b0; b2.shft_i = 1'b0; b2.rot_i = 1'b0;
        b2.inc_i = 1'b0; b2.ser_i = 2'b00; b2.par_i = 32'h0;

        // Apply reset while the inputs toggle randomly.
        for (int i = 0; i < 4; i++) begin
            b8.clr_i = 1'($urandom); b8.ld_i = 1'($urandom); b8.shft_i = 1'($urandom);
            b8.rot_i = 1'($urandom); b8.inc_i = 1'($urandom);
            b8.ser_i = 8'($urandom); b8.par_i = $urandom;
            tick();
        end
        chk("rst_par", 64'(b8.par_o), 64'h0);
        chk("rst_cnt", 64'(b8.cnt_o), 64'h0);
        chk("rst_done", 64'(b8.done_o), 64'h0);
        chk("rst_ovf", 64'(b8.ovf_o), 64'h0);
        idle8();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_par", 64'(b8.par_o), 64'h0);
        chk("post_rst_cnt", 64'(b8.cnt_o), 64'h0);

        // Serial fill.
        b8.shft_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b8.ser_i = 8'(8'h11 * (i + 1));
            tick();
            if (i == 2) chk("fill_done_early", 64'(b8.done_o), 64'h0);
            if (i == 1) chk("fill_cnt_mid", 64'(b8.cnt_o), 64'h2);
        end
        chk("fill_par", 64'(b8.par_o), 64'h44332211);
        chk("fill_cnt", 64'(b8.cnt_o), 64'h0);
        chk("fill_done", 64'(b8.done_o), 64'h1);
        chk("fill_ser", 64'(b8.ser_o), 64'h11);
        idle8();
        tick();
        chk("fill_done_pulse", 64'(b8.done_o), 64'h0);

        // Serial increment with back-to-back shifts.
        b8.ld_i = 1'b1; b8.par_i = 32'h000000FC;
        tick();
        idle8();
        b8.shft_i = 1'b1; b8.rot_i = 1'b1; b8.inc_i = 1'b1;
        repeat (4) tick();
        idle8();
        chk("inc_par", 64'(b8.par_o), 64'h00000100);
        chk("inc_ovf", 64'(b8.ovf_o), 64'h0);
        chk("inc_done", 64'(b8.done_o), 64'h1);

        // Serial increment with one-cycle gaps between shifts.
        b8.ld_i = 1'b1; b8.par_i = 32'h000000FC;
        tick();
        idle8();
        b8.rot_i = 1'b1; b8.inc_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b8.shft_i = 1'b1;
            tick();
            b8.shft_i = 1'b0;
            tick();
            if (i == 1) chk("gap_cnt", 64'(b8.cnt_o), 64'h2);
        end
        chk("gap_par", 64'(b8.par_o), 64'h00000100);
        chk("gap_ovf", 64'(b8.ovf_o), 64'h0);

        // Overflow wrap, followed by clearing through a load and through a new word.
        idle8();
        b8.ld_i = 1'b1; b8.par_i = 32'hFFFFFFFC;
        tick();
        idle8();
        b8.shft_i = 1'b1; b8.rot_i = 1'b1; b8.inc_i = 1'b1;
        repeat (4) tick();
        idle8();
        tick();
        chk("ovf_par", 64'(b8.par_o), 64'h0);
        chk("ovf_flag", 64'(b8.ovf_o), 64'h1);
        b8.ld_i = 1'b1; b8.par_i = 32'h00000005;
        tick();
        idle8();
        chk("ovf_ld_clr", 64'(b8.ovf_o), 64'h0);
        chk("ovf_ld_par", 64'(b8.par_o), 64'h5);
        b8.ld_i = 1'b1; b8.par_i = 32'hFFFFFFFC;
        tick();
        idle8();
        b8.shft_i = 1'b1; b8.rot_i = 1'b1; b8.inc_i = 1'b1;
        repeat (4) tick();
        idle8();
        chk("ovf_again", 64'(b8.ovf_o), 64'h1);
        b8.shft_i = 1'b1; b8.ser_i = 8'h3C;
        tick();
        idle8();
        chk("ovf_newword_clr", 64'(b8.ovf_o), 64'h0);
        chk("newword_cnt", 64'(b8.cnt_o), 64'h1);

        // Clear in the middle of a word.
        b8.clr_i = 1'b1;
        tick();
        idle8();
        b8.shft_i = 1'b1; b8.ser_i = 8'h77;
        repeat (2) tick();
        idle8();
        b8.clr_i = 1'b1;
        tick();
        idle8();
        chk("clr_par", 64'(b8.par_o), 64'h0);
        chk("clr_cnt", 64'(b8.cnt_o), 64'h0);
        chk("clr_done", 64'(b8.done_o), 64'h0);
        tick();
        chk("clr_done_after", 64'(b8.done_o), 64'h0);
        b8.shft_i = 1'b1; b8.ser_i = 8'hA5;
        repeat (4) tick();
        idle8();
        chk("clr_refill", 64'(b8.par_o), 64'hA5A5A5A5);

        // Simultaneous requests, then a pure rotate.
        b8.ld_i = 1'b1; b8.shft_i = 1'b1; b8.ser_i = 8'hFF; b8.par_i = 32'h12345678;
        tick();
        idle8();
        chk("ld_shft_par", 64'(b8.par_o), 64'h12345678);
        chk("ld_shft_cnt", 64'(b8.cnt_o), 64'h0);
        chk("ld_ser", 64'(b8.ser_o), 64'h78);
        b8.shft_i = 1'b1; b8.rot_i = 1'b1;
        tick();
        idle8();
        chk("rot_par", 64'(b8.par_o), 64'h78123456);
        chk("rot_cnt", 64'(b8.cnt_o), 64'h1);
        b8.clr_i = 1'b1; b8.ld_i = 1'b1; b8.par_i = 32'hDEADBEEF;
        tick();
        idle8();
        chk("clr_ld_par", 64'(b8.par_o), 64'h0);

        // Narrow-chunk builds repeat the increment case.
        b1.ld_i = 1'b1; b1.par_i = 32'h000000FC;
        b2.ld_i = 1'b1; b2.par_i = 32'h000000FC;
        tick();
        b1.ld_i = 1'b0; b2.ld_i = 1'b0;
        b1.rot_i = 1'b1; b1.inc_i = 1'b1;
        b2.rot_i = 1'b1; b2.inc_i = 1'b1;
        for (int i = 0; i < 32; i++) begin
            b1.shft_i = 1'b1;
            b2.shft_i = (i < 16);
            tick();
            if (i == 15) chk("b2_inc_par", 64'(b2.par_o), 64'h00000100);
            if (i == 15) chk("b2_inc_done", 64'(b2.done_o), 64'h1);
        end
        b1.shft_i = 1'b0; b2.shft_i = 1'b0;
        chk("b1_inc_par", 64'(b1.par_o), 64'h00000100);
        chk("b1_inc_cnt", 64'(b1.cnt_o), 64'h0);
        chk("b1_inc_done", 64'(b1.done_o), 64'h1);
        chk("b1_inc_ovf", 64'(b1.ovf_o), 64'h0);
        chk("b2_hold", 64'(b2.par_o), 64'h00000100);

        // An asynchronous reset in the middle of a word returns to zero.
        b8.ld_i = 1'b1; b8.par_i = 32'hCAFEF00D;
        tick();
        idle8();
        b8.shft_i = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_par", 64'(b8.par_o), 64'h0);
        chk("async_rst_cnt", 64'(b8.cnt_o), 64'h0);
        idle8();
        tick();
        rst_n = 1'b1;
        tick();
        chk("async_rst_done", 64'(b8.done_o), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fazyrv_spm_addr.md
Name: fazyrv_spm_addr

Overview:
Parametrised address scratchpad that shifts a WIDTH-bit register by BWIDTH-bit chunks, LSB chunk first. It generalises the plain chunk-shift register with a chunk counter, parallel load, synchronous clear, and a rotate mode that adds a constant increment serially with carry (e.g. PC+4) without a full-width adder. It sits beside the PC/address path of the chunked core and exposes the full register in parallel to the memory interface.

Parameters:
BWIDTH, 8, chunk width in bits; legal values are 1, 2, 4, 8.
WIDTH, 32, register width in bits; must be a multiple of BWIDTH.
INC_VAL, 4, constant added in rotate-increment mode; WIDTH bits wide.

Ports:
clk_i  input  1  clock, rising edge
rst_in  input  1  asynchronous active-low reset
clr_i  input  1  synchronous clear of register, counter, carry and flags
ld_i  input  1  parallel load of par_i
par_i  input  WIDTH  parallel load data
shft_i  input  1  advance one chunk this cycle
rot_i  input  1  source select: 0 = ser_i, 1 = rotate own low chunk
inc_i  input  1  in rotate mode, add INC_VAL serially
ser_i  input  BWIDTH  serial input chunk
ser_o  output  BWIDTH  current low chunk (reg[BWIDTH-1:0]), combinational from the register
par_o  output  WIDTH  parallel register content
cnt_o  output  $clog2(WIDTH/BWIDTH) (min 1)  index of the next chunk to be shifted
done_o  output  1  registered one-cycle pulse after the last chunk of a word has been shifted
ovf_o  output  1  registered carry-out of the last increment; sticky until clr_i, ld_i, or the first shift of a new word

Behaviour:
- NCH = WIDTH/BWIDTH. Internal state: reg_r[WIDTH], cnt_r, carry_r, done_r, ovf_r.
- Reset (rst_in=0, asynchronous): reg_r, cnt_r, carry_r, done_o and ovf_o are all 0.
- Priority per cycle: clr_i > ld_i > shft_i. Lower-priority requests in the same cycle are ignored.
- clr_i: reg_r=0, cnt_r=0, carry_r=0, ovf_o=0, done_o=0 next cycle.
- ld_i: reg_r=par_i, cnt_r=0, carry_r=0, ovf_o=0, done_o=0 next cycle.
- shft_i: reg_r <= {new_chunk, reg_r[WIDTH-1:BWIDTH]}. cnt_r increments and wraps from NCH-1 to 0.
  - rot_i=0: new_chunk = ser_i, and carry_r is held at 0.
  - rot_i=1, inc_i=0: new_chunk = reg_r[BWIDTH-1:0] (pure rotate).
  - rot_i=1, inc_i=1: {c, new_chunk} = reg_r[BWIDTH-1:0] + INC_VAL[cnt_r*BWIDTH +: BWIDTH] + cin.
    - cin = 0 when cnt_r==0, else carry_r.
    - carry_r <= c.
    - When cnt_r==NCH-1: ovf_o <= c and carry_r <= 0.
  - First shift of a word (cnt_r==0) clears ovf_o unless that same shift is also the last one (NCH==1).
- done_o: 1 in the cycle after a shift with cnt_r==NCH-1; 0 otherwise.
- Gaps: shft_i may deassert between chunks. State, including carry_r, holds; a partial word resumes correctly.
- Mid-word mode change: legal but undefined arithmetically; carry_r still follows the rules above.
- Latency: par_o, ser_o and cnt_o reflect a shift, load or clear on the next cycle.
- Reset mid-word: immediate return to reset state; no done_o pulse is produced.

Test Plan:
- Reset: hold rst_in=0 with random inputs -> par_o=0, cnt_o=0, done_o=0, ovf_o=0; release -> values unchanged until a request.
- Serial fill (BWIDTH=8): rot_i=0; shift ser_i 0x11, 0x22, 0x33, 0x44 -> par_o=0x44332211, cnt_o back to 0, done_o high exactly one cycle after the 4th shift.
- Increment with carry: ld 0x000000FC, then 4 shifts with rot_i=1, inc_i=1 -> par_o=0x00000100, ovf_o=0. Repeat with 1-cycle gaps between shifts -> same result.
- Overflow wrap: ld 0xFFFFFFFC, 4 increment shifts -> par_o=0x00000000, ovf_o=1. Next ld -> ovf_o=0.
- Clear mid-word: 2 serial shifts, then clr_i -> par_o=0, cnt_o=0, no done_o. A following 4-shift fill of 0xA5 chunks -> 0xA5A5A5A5.
- Simultaneous requests: ld_i and shft_i in the same cycle with par_i=0x12345678 -> par_o=0x12345678, cnt_o=0. clr_i with ld_i -> par_o=0. BWIDTH=1 and BWIDTH=2 builds rerun the increment case (32 and 16 shifts) -> 0x00000100.
